sysid_check_ctrl: RTL and testbench
===================================

# sysid_check_ctrl

Boot-time sequencer that reads the two 32-bit words of the system-ID slave through an Avalon-MM read master: word 0 is the ID and word 1 is the build timestamp. It compares both words against expected parameters and reports pass or fail to the host status register and to the acquisition-enable logic. It handles slave wait states, bus timeouts and bounded retries, so acquisition on the SS-OCT board starts only after the loaded image has been confirmed.

## Interface
- EXPECTED_ID, 32'h4BB5C951, expected word at address 0
- EXPECTED_TS, 32'h4E0340BE, expected word at address 1
- TIMEOUT_CYC, 255, max cycles a read may stay stalled by waitrequest; 8-bit counter
- MAX_RETRY, 3, extra full sequences after a timeout or mismatch; 0..15
- PERIOD_CYC, 50000000, recheck interval; used only with the macro in Configuration
- clk, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- start, in, 1, single-cycle pulse; begins a check sequence; ignored while busy
- avm_address, out, 1, word select for the system-ID slave
- avm_read, out, 1, read strobe
- avm_waitrequest, in, 1, slave stall
- avm_readdata, in, 32, slave read data
- busy, out, 1, high from accepted start until done
- done, out, 1, single-cycle pulse at end of sequence
- pass, out, 1, sticky; last sequence matched both words
- fail, out, 1, sticky; last sequence exhausted retries
- err_code, out, 2, 0 none, 1 ID mismatch, 2 TS mismatch, 3 timeout
- id_word, out, 32, last captured word 0
- ts_word, out, 32, last captured word 1

## Operation
- FSM states: IDLE, RD_ID, RD_TS, CMP, RETRY, FIN.
- **IDLE:** `start` clears `pass`, `fail`, `err_code` and the retry counter, then goes to RD_ID.
- **RD_ID:** `avm_read`=1 and `avm_address`=0, held stable while `avm_waitrequest`=1.
  - First cycle with `avm_waitrequest`=0: latch `avm_readdata` into `id_word`, then go to RD_TS.
- **RD_TS:** same as RD_ID with `avm_address`=1; latches `ts_word`, then goes to CMP.
- **Timeout:** a counter resets on entry to each read state and increments each stalled cycle.
  - When the count reaches TIMEOUT_CYC with `avm_waitrequest` still 1: drop `avm_read`, set `err_code`=3, go to RETRY.
- **CMP** (one cycle): checks the ID first.
  - ID mismatch: `err_code`=1.
  - Otherwise TS mismatch: `err_code`=2.
  - Both match: `err_code`=0, go to FIN with pass.
  - Any mismatch: go to RETRY.
- **RETRY:**
  - Retry counter below MAX_RETRY: increment it and go to RD_ID.
  - Otherwise: go to FIN with fail.
- **FIN:** one cycle.
  - Asserts `done`.
  - Sets `pass` or `fail`; never both.
  - Returns to IDLE.
- `err_code` keeps the cause of the last failed attempt. It reads 0 only after a pass.
- `start` outside IDLE is dropped; it is not queued.

## Timing
- Reset values: FSM=IDLE; `avm_read`, `avm_address`, `busy`, `done`, `pass`, `fail` = 0; `err_code`=0; `id_word`=`ts_word`=0; all counters 0.
- `start` sampled in cycle N → `avm_read`=1 in cycle N+1; `busy` is registered and also rises in N+1.
- Zero wait states: start(N), RD_ID(N+1), RD_TS(N+2), CMP(N+3), FIN with `done` (N+4); `busy` falls in N+5.
- Each wait-state cycle adds one cycle. A timed-out read lasts TIMEOUT_CYC+1 cycles including the issue cycle.
- RETRY costs one cycle; the next read issues the cycle after RETRY.
- `avm_read` is never high in CMP, RETRY, FIN or IDLE.
- `avm_address` changes only on a cycle where `avm_waitrequest`=0 or at timeout.
- `reset_n` low mid-sequence: all outputs return to reset values immediately. No partial result is reported, and `avm_read` drops asynchronously.
- `avm_waitrequest` falling on the same cycle the timeout count is reached: the data is accepted; accepting wins over timeout.

## Configuration
- **`SYSID_CHECK_PERIODIC_EN` defined:** a 32-bit interval counter runs while in IDLE after the first completed sequence.
  - After PERIOD_CYC cycles it launches an internal start, equivalent to the `start` pulse.
  - An external `start` restarts the interval counter.
  - A failed periodic check sets `fail`. `pass` stays cleared until the next passing sequence.
- **Undefined:** no interval counter, PERIOD_CYC is ignored, and sequences run only on `start`.

## Test plan
- **Nominal pass:** reset, zero wait states, slave returns 4BB5C951/4E0340BE, pulse `start` → `done` at start+4, `pass`=1, `err_code`=0, `id_word`/`ts_word` equal those values.
- **Wait states:** 3 wait cycles on each read → `done` at start+10, `pass`=1, address and read held stable while stalled.
- **TS mismatch with recovery:** MAX_RETRY=3, first two sequences return TS 0 and the third is correct → `pass`=1, `err_code`=0, 3 read pairs observed.
- **Permanent timeout:** `avm_waitrequest` stuck at 1, TIMEOUT_CYC=255, MAX_RETRY=3 → 4 timeouts, `fail`=1, `err_code`=3, `avm_read` low after FIN.
- **Reset mid-read:** `reset_n` low during stalled RD_TS → outputs go to reset values immediately; a new `start` after release → nominal pass.
- **Periodic (macro defined):** PERIOD_CYC=100 → a second read pair starts 100 cycles after the first `done`; changing slave data to a wrong ID gives `fail`=1, `err_code`=1.

Source files
------------

// File: rtl/sysid_check_ctrl_if.sv
// sysid_check_ctrl_if
//   Avalon-MM read-only link between the boot-time ID checker and the
//   system-ID slave.
//   Signals:
//     avm_address     - word select (0 = ID, 1 = build timestamp)
//     avm_read        - read strobe
//     avm_waitrequest - slave stall
//     avm_readdata    - 32-bit read data
//   Modports:
//     master - the checker (drives address/read)
//     slave  - the system-ID slave (drives waitrequest/readdata)
interface sysid_check_ctrl_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl
//   Boot-time sequencer. It reads the ID word (address 0) and the build
//   timestamp (address 1) from the system-ID slave, then compares both
//   against EXPECTED_ID / EXPECTED_TS. It retries up to MAX_RETRY extra
//   times after a mismatch or a stalled-read timeout, and finally reports
//   pass or fail.
//   Ports:
//     clk, reset_n  - clock, asynchronous active-low reset
//     start         - one-cycle request, ignored unless idle
//     avm           - Avalon-MM read master (sysid_check_ctrl_if.master)
//     busy          - high from the accepted start until the sequence ends
//     done          - one-cycle pulse on the final cycle of a sequence
//     pass / fail   - sticky verdict of the last sequence
//     err_code      - cause of the last failed attempt
//                     (0 none, 1 ID, 2 TS, 3 timeout)
//     id_word       - last captured ID word
//     ts_word       - last captured timestamp word
//   Build option:
//     SYSID_CHECK_PERIODIC_EN - when defined, the check re-runs by itself
//     every PERIOD_CYC idle cycles after the first completed sequence.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID = 32'h4BB5C951,
  parameter logic [31:0] EXPECTED_TS = 32'h4E0340BE,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned PERIOD_CYC  = 50000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  sysid_check_ctrl_if.master        avm,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic [1:0]                err_code,
  output logic [31:0]               id_word,
  output logic [31:0]               ts_word
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_ID = 3'd1;
  localparam logic [2:0] S_RD_TS = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_RETRY = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [7:0] TMO_LIMIT   = 8'(TIMEOUT_CYC);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  logic [2:0]  state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [3:0]  retry_q, retry_d;
  logic        busy_q, busy_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        start_go;

`ifdef SYSID_CHECK_PERIODIC_EN
  // Interval timer. It counts from the FIN cycle through the idle cycles
  // so that the internal start lands exactly PERIOD_CYC cycles after done.
  // Leaving IDLE for any reason (including an external start) clears it.
  localparam logic [31:0] PERIOD_LIMIT = 32'(PERIOD_CYC - 1);

  logic [31:0] period_cnt_q, period_cnt_d;
  logic        armed_q, armed_d;

  always_comb begin
    armed_d      = armed_q | (state_q == S_FIN);
    period_cnt_d = 32'd0;
    if ((state_q == S_FIN) || ((state_q == S_IDLE) && !start_go))
      period_cnt_d = period_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt_q <= 32'd0;
      armed_q      <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      armed_q      <= armed_d;
    end
  end

  assign start_go = start |
                    (armed_q && (state_q == S_IDLE) && (period_cnt_q >= PERIOD_LIMIT));
`else
  logic unused_period;
  assign unused_period = ^PERIOD_CYC;
  assign start_go      = start;
`endif

  // Sequencer. An accepted beat always takes priority over the timeout
  // check, so data that arrives on the limit cycle is still used.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;
    id_d    = id_q;
    ts_d    = ts_q;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          err_d   = 2'd0;
          retry_d = 4'd0;
          tmo_d   = 8'd0;
          state_d = S_RD_ID;
        end
      end
      S_RD_ID: begin
        if (!avm.avm_waitrequest) begin
          id_d    = avm.avm_readdata;
          tmo_d   = 8'd0;
          state_d = S_RD_TS;
        end else if (tmo_q == TMO_LIMIT) begin
          err_d   = 2'd3;
          state_d = S_RETRY;
        end else begin
          tmo_d   = tmo_q + 8'd1;
        end
      end
      S_RD_TS: begin
        if (!avm.avm_waitrequest) begin
          ts_d    = avm.avm_readdata;
          state_d = S_CMP;
        end else if (tmo_q == TMO_LIMIT) begin
          err_d   = 2'd3;
          state_d = S_RETRY;
        end else begin
          tmo_d   = tmo_q + 8'd1;
        end
      end
      S_CMP: begin
        if (id_q != EXPECTED_ID) begin
          err_d   = 2'd1;
          state_d = S_RETRY;
        end else if (ts_q != EXPECTED_TS) begin
          err_d   = 2'd2;
          state_d = S_RETRY;
        end else begin
          err_d   = 2'd0;
          pass_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_RETRY: begin
        if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 4'd1;
          tmo_d   = 8'd0;
          state_d = S_RD_ID;
        end else begin
          fail_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tmo_q   <= 8'd0;
      retry_q <= 4'd0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= 2'd0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  // Bus strobes decode straight from the state register, so they stay
  // stable through a stall and drop the instant reset is asserted.
  assign avm.avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
  assign avm.avm_address = (state_q == S_RD_TS);

  assign busy     = busy_q;
  assign done     = (state_q == S_FIN);
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign err_code = err_q;
  assign id_word  = id_q;
  assign ts_word  = ts_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
`timescale 1ns/1ps
// Bench for sysid_check_ctrl: a reactive system-ID slave plays a planned
// list of reads (wait count + data per read, in issue order), and a
// transaction-level model turns the same plan into the expected
// cycle-by-cycle outputs.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID  = 32'h4BB5C951;
  localparam logic [31:0] EXP_TS  = 32'h4E0340BE;
  localparam int          TMO     = 255;
  localparam int          RETRIES = 3;
  localparam int          STUCK   = 1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy, done, pass, fail;
  logic [1:0]  err_code;
  logic [31:0] id_word, ts_word;

  sysid_check_ctrl_if bus ();

  sysid_check_ctrl #(
    .EXPECTED_ID (EXP_ID),
    .EXPECTED_TS (EXP_TS),
    .TIMEOUT_CYC (TMO),
    .MAX_RETRY   (RETRIES),
    .PERIOD_CYC  (100)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .avm      (bus),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .err_code (err_code),
    .id_word  (id_word),
    .ts_word  (ts_word)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  string       curName;

  int          plan_wait [0:31];
  logic [31:0] plan_data [0:31];
  int          ridx;
  int          readsSeen;

  logic [7:0]  exp_ctl [$];
  logic [31:0] exp_id  [$];
  logic [31:0] exp_ts  [$];
  logic [31:0] model_id = 32'd0;
  logic [31:0] model_ts = 32'd0;

  // Reactive slave: each new read (strobe rising or address change) takes
  // the next plan entry, stalls for its wait count, then returns its data.
  initial begin
    logic prevRead;
    logic prevAddr;
    int   cur;
    int   stall;
    prevRead = 1'b0;
    prevAddr = 1'b0;
    cur      = 0;
    stall    = 0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.avm_read === 1'b1) begin
        if (!prevRead || (bus.avm_address !== prevAddr)) begin
          cur   = (ridx > 31) ? 31 : ridx;
          ridx  = ridx + 1;
          stall = 0;
          readsSeen = readsSeen + 1;
        end
        if (stall < plan_wait[cur]) begin
          bus.avm_waitrequest = 1'b1;
          bus.avm_readdata    = $urandom;
          stall = stall + 1;
        end else begin
          bus.avm_waitrequest = 1'b0;
          bus.avm_readdata    = plan_data[cur];
        end
      end else begin
        bus.avm_waitrequest = 1'($urandom_range(0, 1));
        bus.avm_readdata    = $urandom;
      end
      prevRead = (bus.avm_read === 1'b1);
      prevAddr = (bus.avm_address === 1'b1);
    end
  end

  task automatic pushCycle(input logic rd, input logic ad, input logic bz, input logic dn,
                           input logic p, input logic f, input logic [1:0] e);
    exp_ctl.push_back({rd, ad, bz, dn, p, f, e});
    exp_id.push_back(model_id);
    exp_ts.push_back(model_ts);
  endtask

  // Expected outputs from cycle N+1 (N = start cycle): each read lasts
  // (waits+1) cycles, or TMO+1 cycles if it never completes; a full pair is
  // followed by one compare cycle; a failed attempt costs one more cycle
  // before the next attempt; the verdict cycle carries done.
  task automatic buildModel();
    int         r;
    int         attempt;
    int         dur;
    bit         finished;
    bit         timedOut;
    logic       p, f;
    logic [1:0] e;
    exp_ctl.delete();
    exp_id.delete();
    exp_ts.delete();
    r = 0; attempt = 0; finished = 0;
    p = 1'b0; f = 1'b0; e = 2'd0;
    while (!finished) begin
      timedOut = 0;
      for (int w = 0; w < 2 && !timedOut; w++) begin
        dur = (plan_wait[r] > TMO) ? TMO + 1 : plan_wait[r] + 1;
        for (int i = 0; i < dur; i++) pushCycle(1'b1, (w == 1), 1'b1, 1'b0, p, f, e);
        if (plan_wait[r] > TMO) begin
          timedOut = 1;
          e = 2'd3;
        end else if (w == 0) model_id = plan_data[r];
        else model_ts = plan_data[r];
        r++;
      end
      if (!timedOut) begin
        pushCycle(1'b0, 1'b0, 1'b1, 1'b0, p, f, e);
        if (model_id != EXP_ID) e = 2'd1;
        else if (model_ts != EXP_TS) e = 2'd2;
        else begin
          e = 2'd0;
          p = 1'b1;
          pushCycle(1'b0, 1'b0, 1'b1, 1'b1, p, f, e);
          finished = 1;
        end
      end
      if (!finished) begin
        pushCycle(1'b0, 1'b0, 1'b1, 1'b0, p, f, e);
        if (attempt < RETRIES) attempt++;
        else begin
          f = 1'b1;
          pushCycle(1'b0, 1'b0, 1'b1, 1'b1, p, f, e);
          finished = 1;
        end
      end
    end
    repeat (2) pushCycle(1'b0, 1'b0, 1'b0, 1'b0, p, f, e);
  endtask

  task automatic checkOutput(input int k);
    logic [7:0] act;
    act = {bus.avm_read, bus.avm_address, busy, done, pass, fail, err_code};
    total++;
    if (act !== exp_ctl[k] || id_word !== exp_id[k] || ts_word !== exp_ts[k]) begin
      bad++;
      $display("[TB] FAIL %s cyc N+%0d: got rd/ad/busy/done/pass/fail/err=%b id=%h ts=%h, want %b id=%h ts=%h",
               curName, k + 1, act, id_word, ts_word, exp_ctl[k], exp_id[k], exp_ts[k]);
    end
  endtask

  task automatic checkLit(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Runs one sequence from a start pulse, comparing every cycle until the
  // model's trailing idle cycles. With noise set, extra start pulses are
  // thrown in while the model says the block is busy.
  task automatic applyStimulus(input string name, input bit noise, output int doneAt);
    curName = name;
    buildModel();
    ridx = 0;
    readsSeen = 0;
    @(negedge clk);
    start = 1'b1;
    doneAt = -1;
    for (int k = 0; k < exp_ctl.size(); k++) begin
      @(negedge clk);
      checkOutput(k);
      if (done === 1'b1 && doneAt < 0) doneAt = k + 1;
      start = noise && exp_ctl[k][5] && ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
  endtask

  task automatic planNominal(input int waits);
    for (int i = 0; i < 32; i++) begin
      plan_wait[i] = waits;
      plan_data[i] = (i % 2 == 0) ? EXP_ID : EXP_TS;
    end
  endtask

  task automatic planRandom();
    int sel;
    for (int i = 0; i < 32; i++) begin
      sel = $urandom_range(0, 39);
      if (sel < 34)      plan_wait[i] = $urandom_range(0, 4);
      else if (sel < 36) plan_wait[i] = TMO;
      else if (sel < 38) plan_wait[i] = TMO + 1;
      else               plan_wait[i] = STUCK;
      plan_data[i] = (i % 2 == 0) ? EXP_ID : EXP_TS;
      if ($urandom_range(0, 4) == 0) plan_data[i] = $urandom;
    end
  endtask

  initial begin
    int doneAt;
    reset_n   = 1'b1;
    start     = 1'b0;
    ridx      = 0;
    readsSeen = 0;
    planNominal(0);
    #2 reset_n = 1'b0;
    #20;
    checkLit("reset ctl", 32'({bus.avm_read, bus.avm_address, busy, done, pass, fail, err_code}), 32'd0);
    checkLit("reset id_word", id_word, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] nominal pass");
    planNominal(0);
    applyStimulus("nominal", 1'b0, doneAt);
    checkLit("nominal done cycle", 32'(doneAt), 32'd4);
    checkLit("nominal pass", 32'(pass), 32'd1);
    checkLit("nominal id_word", id_word, 32'h4BB5C951);
    checkLit("nominal ts_word", ts_word, 32'h4E0340BE);

    $display("[TB] three wait states per read");
    planNominal(3);
    applyStimulus("waits3", 1'b1, doneAt);
    checkLit("waits3 done cycle", 32'(doneAt), 32'd10);

    $display("[TB] TS mismatch twice then recovery");
    planNominal(0);
    plan_data[1] = 32'd0;
    plan_data[3] = 32'd0;
    applyStimulus("tsretry", 1'b0, doneAt);
    checkLit("tsretry read count", 32'(readsSeen), 32'd6);
    checkLit("tsretry pass/err", 32'({pass, err_code}), 32'b100);

    $display("[TB] permanent timeout");
    planNominal(STUCK);
    applyStimulus("timeout", 1'b1, doneAt);
    checkLit("timeout read count", 32'(readsSeen), 32'd4);
    checkLit("timeout done cycle", 32'(doneAt), 32'd1029);
    checkLit("timeout fail/err", 32'({fail, pass, err_code}), 32'b1011);

    $display("[TB] accept on the timeout limit cycle, then TS timeout");
    planNominal(0);
    plan_wait[0] = TMO;
    plan_wait[1] = TMO + 1;
    applyStimulus("boundary", 1'b0, doneAt);
    checkLit("boundary pass", 32'(pass), 32'd1);

    $display("[TB] reset during stalled TS read");
    planNominal(0);
    plan_wait[1] = STUCK;
    ridx = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checkLit("pre-reset ts stall", 32'({bus.avm_read, bus.avm_address, busy}), 32'b111);
    #2 reset_n = 1'b0;
    #1;
    checkLit("midreset ctl", 32'({bus.avm_read, bus.avm_address, busy, done, pass, fail, err_code}), 32'd0);
    checkLit("midreset id_word", id_word, 32'd0);
    model_id = 32'd0;
    model_ts = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    planNominal(0);
    applyStimulus("afterreset", 1'b0, doneAt);
    checkLit("afterreset done cycle", 32'(doneAt), 32'd4);

    $display("[TB] randomized sequences");
    for (int s = 0; s < 14; s++) begin
      planRandom();
      applyStimulus($sformatf("rand%0d", s), 1'b1, doneAt);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
